// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory controller.
//   state_e      : controller FSM states
//   SEL_*        : byte-lane masks (sel[3] = bits 31:24 = byte address 00)
//   RD_LAT_MIN/MAX : legal bounds for the SRAM read latency parameter
//   lanes_legal  : lane-mask / byte-offset alignment rule
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam logic [3:0] SEL_WORD = 4'b1111;
    localparam logic [3:0] SEL_HI   = 4'b1100;
    localparam logic [3:0] SEL_LO   = 4'b0011;
    localparam logic [3:0] SEL_B0   = 4'b1000;
    localparam logic [3:0] SEL_B1   = 4'b0100;
    localparam logic [3:0] SEL_B2   = 4'b0010;
    localparam logic [3:0] SEL_B3   = 4'b0001;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;

    // True when the lane mask is a legal access for the given byte offset.
    // An empty mask never matches, so it reports as misaligned.
    function automatic logic lanes_legal(input logic [3:0] sel, input logic [1:0] off);
        logic ok;
        case (sel)
            SEL_WORD, SEL_HI: ok = (off == 2'b00);
            SEL_LO:           ok = (off == 2'b10);
            SEL_B0:           ok = (off == 2'b00);
            SEL_B1:           ok = (off == 2'b01);
            SEL_B2:           ok = (off == 2'b10);
            SEL_B3:           ok = (off == 2'b11);
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the mem stage (master) and the data-memory
// controller (slave).
//   mem_ce_i/mem_wr_i/mem_sel_i/mem_addr_i/mem_wdata_i : request from mem stage
//   mem_rdata_o : full 32-bit load word
//   done_o/err_o : one-cycle completion / error pulses
//   stall_o     : pipeline hold request
interface dmem_ctrl_if;
    logic        mem_ce_i;
    logic        mem_wr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        done_o;
    logic        err_o;
    logic        stall_o;

    modport master (
        output mem_ce_i, mem_wr_i, mem_sel_i, mem_addr_i, mem_wdata_i,
        input  mem_rdata_o, done_o, err_o, stall_o
    );

    modport slave (
        input  mem_ce_i, mem_wr_i, mem_sel_i, mem_addr_i, mem_wdata_i,
        output mem_rdata_o, done_o, err_o, stall_o
    );
endinterface

// File: rtl/dmem_ctrl_sram.sv
// Single-port data SRAM, 2^DEPTH_LOG2 x 32 bits, per-lane write enable.
// Reads are registered and pass through an RD_LAT-deep output pipe, so data
// for a read issued in cycle T is on rdata_o during cycle T+RD_LAT.
//   clk     : clock
//   we_i    : write enable (lanes selected by be_i, be_i[0] = bits 7:0)
//   re_i    : read enable
//   idx_i   : word index
//   wdata_i : write data
//   rdata_o : read data from the last pipe stage
module dmem_sram #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] idx_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q  [2**DEPTH_LOG2];
    logic [31:0] pipe_q [RD_LAT];
    logic [31:0] merged;

    // Stored word with the enabled lanes replaced; also the read value on a
    // same-cycle write, which makes the array write-first.
    always_comb begin
        merged = mem_q[idx_i];
        for (int unsigned b = 0; b < 4; b++) begin
            if (we_i && be_i[b]) merged[8*b +: 8] = wdata_i[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) mem_q[idx_i] <= merged;
        if (re_i) pipe_q[0] <= merged;
        for (int unsigned s = 1; s < RD_LAT; s++) pipe_q[s] <= pipe_q[s-1];
    end

    assign rdata_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller downstream of the mem stage. Checks each request for
// alignment and range, completes stores in one cycle, and holds the pipeline
// on loads until the SRAM word (RD_LAT cycles) is available.
//   clk : clock, rising edge
//   rst : synchronous reset, active-low
//   bus : dmem_ctrl_if slave (request in; rdata/done/err/stall out)
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus
);

    state_e      state_q;
    logic [1:0]  cnt_q;
    logic [31:0] rdata_q;
    logic        done_q;
    logic        err_q;

    logic        in_range;
    logic        legal;
    logic        idle_req;
    logic        accept_st;
    logic        accept_ld;
    logic        req_bad;
    logic [31:0] sram_rdata;

    always_comb begin
        in_range  = ~|bus.mem_addr_i[31:DEPTH_LOG2+2];
        legal     = in_range & lanes_legal(bus.mem_sel_i, bus.mem_addr_i[1:0]);
        idle_req  = (state_q == IDLE) & bus.mem_ce_i;
        accept_st = idle_req & legal & bus.mem_wr_i;
        accept_ld = idle_req & legal & ~bus.mem_wr_i;
        req_bad   = idle_req & ~legal;
    end

    dmem_sram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .RD_LAT     (RD_LAT)
    ) u_sram (
        .clk     (clk),
        .we_i    (accept_st & rst),
        .re_i    (accept_ld),
        .idx_i   (bus.mem_addr_i[DEPTH_LOG2+1:2]),
        .be_i    (bus.mem_sel_i),
        .wdata_i (bus.mem_wdata_i),
        .rdata_o (sram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_st) done_q <= 1'b1;
                    if (req_bad)   err_q  <= 1'b1;
                    if (accept_ld) begin
                        if (RD_LAT == 1) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RD_WAIT;
                            cnt_q   <= 2'(RD_LAT - 1);
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == 2'd1) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                DONE: begin
                    // Request inputs are deliberately ignored here.
                    state_q <= IDLE;
                    rdata_q <= sram_rdata;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The SRAM word first becomes valid in DONE, out of the SRAM's own output
    // register; it is shown directly that cycle and held in rdata_q after.
    assign bus.mem_rdata_o = (state_q == DONE) ? sram_rdata : rdata_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.stall_o     = rst & (accept_ld | (state_q == RD_WAIT));

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: three instances with RD_LAT = 1, 3, 4,
// directed scenarios plus randomized traffic against a word/byte-level model.
module tb_dmem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_ctrl_if bus1 ();
    dmem_ctrl_if bus3 ();
    dmem_ctrl_if bus4 ();

    dmem_ctrl #(.DEPTH_LOG2(10), .RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    dmem_ctrl #(.DEPTH_LOG2(10), .RD_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));
    dmem_ctrl #(.DEPTH_LOG2(10), .RD_LAT(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rd3 = '0;

    task automatic set_bus(input int which, input logic ce, input logic wr,
                           input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] wd);
        case (which)
            1: begin bus1.mem_ce_i = ce; bus1.mem_wr_i = wr; bus1.mem_sel_i = sel;
                     bus1.mem_addr_i = addr; bus1.mem_wdata_i = wd; end
            3: begin bus3.mem_ce_i = ce; bus3.mem_wr_i = wr; bus3.mem_sel_i = sel;
                     bus3.mem_addr_i = addr; bus3.mem_wdata_i = wd; end
            default: begin bus4.mem_ce_i = ce; bus4.mem_wr_i = wr; bus4.mem_sel_i = sel;
                     bus4.mem_addr_i = addr; bus4.mem_wdata_i = wd; end
        endcase
    endtask

    task automatic get_out(input int which, output logic st, output logic dn,
                           output logic er, output logic [31:0] rd);
        case (which)
            1:       begin st = bus1.stall_o; dn = bus1.done_o; er = bus1.err_o; rd = bus1.mem_rdata_o; end
            3:       begin st = bus3.stall_o; dn = bus3.done_o; er = bus3.err_o; rd = bus3.mem_rdata_o; end
            default: begin st = bus4.stall_o; dn = bus4.done_o; er = bus4.err_o; rd = bus4.mem_rdata_o; end
        endcase
    endtask

    // Drives one request like the mem stage (held while stall_o is high) and
    // records what came back over a fixed 8-cycle window. No checking here.
    task automatic xact(input int which, input logic wr, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int n_stall, output int n_done, output int n_err,
                        output int done_at, output int err_at,
                        output logic [31:0] rd_done, output logic [31:0] rd_end);
        logic st, dn, er;
        logic [31:0] rd;
        bit dropped;
        dropped = 0;
        n_stall = 0; n_done = 0; n_err = 0; done_at = -1; err_at = -1;
        rd_done = 'x; rd_end = 'x;
        @(posedge clk); #1 set_bus(which, 1'b1, wr, sel, addr, wd);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            get_out(which, st, dn, er, rd);
            if (st) n_stall++;
            if (dn) begin n_done++; if (done_at < 0) begin done_at = c; rd_done = rd; end end
            if (er) begin n_err++;  if (err_at < 0) err_at = c; end
            rd_end = rd;
            if (!st && !dropped) begin
                @(posedge clk); #1 set_bus(which, 1'b0, 1'b0, '0, '0, '0);
                dropped = 1;
            end
        end
        if (!dropped) set_bus(which, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset();
        logic st, dn, er;
        logic [31:0] rd;
        int ns, nd, ne, da, ea;
        logic [31:0] rdd, rde;
        rst = 1'b0;
        set_bus(3, 1'b1, 1'b0, 4'hF, 32'h10, '0);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            get_out(3, st, dn, er, rd);
            checks++;
            if (st !== 1'b0 || dn !== 1'b0 || rd !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs got stall=%b done=%b rdata=%h expected 0/0/00000000", st, dn, rd);
            end
        end
        get_out(4, st, dn, er, rd);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL reset_lat4 got rdata=%h err=%b expected 00000000/0", rd, er);
        end
        @(posedge clk); #1 rst = 1'b1; set_bus(3, 1'b0, 1'b0, '0, '0, '0);
        xact(3, 1'b0, 4'hF, 32'h10, '0, ns, nd, ne, da, ea, rdd, rde);
        checks++;
        if (ns !== 3 || nd !== 1 || da !== 3 || ne !== 0) begin
            errors++;
            $display("FAIL reset_first_load got stall=%0d done=%0d@%0d err=%0d expected 3 1@3 0", ns, nd, da, ne);
        end
    endtask

    task automatic test_word();
        int ns, nd, ne, da, ea;
        logic [31:0] rdd, rde;
        xact(3, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, ns, nd, ne, da, ea, rdd, rde);
        checks++;
        if (ns !== 0 || nd !== 1 || da !== 1 || ne !== 0) begin
            errors++;
            $display("FAIL word_store got stall=%0d done=%0d@%0d err=%0d expected 0 1@1 0", ns, nd, da, ne);
        end
        xact(3, 1'b0, 4'hF, 32'h10, '0, ns, nd, ne, da, ea, rdd, rde);
        checks++;
        if (ns !== 3 || nd !== 1 || da !== 3 || ne !== 0) begin
            errors++;
            $display("FAIL word_load_timing got stall=%0d done=%0d@%0d err=%0d expected 3 1@3 0", ns, nd, da, ne);
        end
        checks++;
        if (rdd !== 32'hDEADBEEF || rde !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_load_data got %h/%h expected deadbeef", rdd, rde);
        end
        exp_rd3 = 32'hDEADBEEF;
    endtask

    task automatic test_lanes();
        int ns, nd, ne, da, ea;
        logic [31:0] rdd, rde;
        xact(3, 1'b1, 4'b1111, 32'h20, 32'h11223344, ns, nd, ne, da, ea, rdd, rde);
        xact(3, 1'b1, 4'b0100, 32'h21, 32'hAAAAAAAA, ns, nd, ne, da, ea, rdd, rde);
        checks++;
        if (nd !== 1 || ne !== 0) begin
            errors++;
            $display("FAIL lanes_byte_store got done=%0d err=%0d expected 1 0", nd, ne);
        end
        xact(3, 1'b1, 4'b0011, 32'h22, 32'h55665566, ns, nd, ne, da, ea, rdd, rde);
        checks++;
        if (nd !== 1 || ne !== 0) begin
            errors++;
            $display("FAIL lanes_half_store got done=%0d err=%0d expected 1 0", nd, ne);
        end
        xact(3, 1'b0, 4'b1111, 32'h20, '0, ns, nd, ne, da, ea, rdd, rde);
        checks++;
        if (rdd !== 32'h11AA5566) begin
            errors++;
            $display("FAIL lanes_merge got %h expected 11aa5566", rdd);
        end
        exp_rd3 = 32'h11AA5566;
    endtask

    task automatic test_errors();
        logic [3:0]  e_sel  [6] = '{4'b1100, 4'b1000, 4'b1111, 4'b1111, 4'b0000, 4'b0110};
        logic [31:0] e_addr [6] = '{32'h22, 32'h23, 32'h1000, 32'h1020, 32'h20, 32'h21};
        logic        e_wr   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int ns, nd, ne, da, ea;
        logic [31:0] rdd, rde;
        for (int i = 0; i < 6; i++) begin
            xact(3, e_wr[i], e_sel[i], e_addr[i], 32'hFFFFFFFF, ns, nd, ne, da, ea, rdd, rde);
            checks++;
            if (ne !== 1 || ea !== 1 || nd !== 0 || ns !== 0 || rde !== exp_rd3) begin
                errors++;
                $display("FAIL err_case%0d got err=%0d@%0d done=%0d stall=%0d rdata=%h expected 1@1 0 0 %h",
                         i, ne, ea, nd, ns, rde, exp_rd3);
            end
        end
        xact(3, 1'b0, 4'hF, 32'h20, '0, ns, nd, ne, da, ea, rdd, rde);
        checks++;
        if (rdd !== 32'h11AA5566) begin
            errors++;
            $display("FAIL err_mem_intact got %h expected 11aa5566", rdd);
        end
        xact(3, 1'b1, 4'hF, 32'hFFC, 32'hA5A50F0F, ns, nd, ne, da, ea, rdd, rde);
        xact(3, 1'b0, 4'b0001, 32'hFFF, '0, ns, nd, ne, da, ea, rdd, rde);
        checks++;
        if (ne !== 0 || nd !== 1 || rdd !== 32'hA5A50F0F) begin
            errors++;
            $display("FAIL err_last_word got err=%0d done=%0d rdata=%h expected 0 1 a5a50f0f", ne, nd, rdd);
        end
        exp_rd3 = 32'hA5A50F0F;
    endtask

    task automatic test_back_to_back();
        logic st, dn, er;
        logic [31:0] rd;
        @(posedge clk); #1 set_bus(1, 1'b1, 1'b1, 4'hF, 32'h30, 32'h1);
        @(negedge clk); get_out(1, st, dn, er, rd);
        checks++;
        if (st !== 1'b0) begin errors++; $display("FAIL b2b_store_stall got %b expected 0", st); end
        @(posedge clk); #1 set_bus(1, 1'b1, 1'b0, 4'hF, 32'h30, 32'h0);
        @(negedge clk); get_out(1, st, dn, er, rd);
        checks++;
        if (st !== 1'b1 || dn !== 1'b1) begin
            errors++; $display("FAIL b2b_issue got stall=%b done=%b expected 1 1", st, dn);
        end
        @(posedge clk); @(negedge clk); get_out(1, st, dn, er, rd);
        checks++;
        if (st !== 1'b0 || dn !== 1'b1 || rd !== 32'h1) begin
            errors++; $display("FAIL b2b_done got stall=%b done=%b rdata=%h expected 0 1 00000001", st, dn, rd);
        end
        @(posedge clk); #1 set_bus(1, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk); get_out(1, st, dn, er, rd);
        checks++;
        if (st !== 1'b0 || dn !== 1'b0 || rd !== 32'h1) begin
            errors++; $display("FAIL b2b_no_reissue got stall=%b done=%b rdata=%h expected 0 0 00000001", st, dn, rd);
        end
    endtask

    task automatic test_random();
        logic [3:0]  sel_tab [7] = '{4'b1111, 4'b1100, 4'b0011, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
        logic [1:0]  off_tab [7] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
        logic [31:0] mdl [int];
        int ns, nd, ne, da, ea, idx, k;
        int e_ns, e_nd, e_da, e_ne;
        logic [31:0] rdd, rde, addr, wd, w;
        logic [3:0]  sel;
        logic [1:0]  off;
        logic        wr, oor, legal;
        for (int i = 64; i < 80; i++) begin
            wd = $urandom;
            xact(3, 1'b1, 4'hF, i * 4, wd, ns, nd, ne, da, ea, rdd, rde);
            mdl[i] = wd;
        end
        for (int n = 0; n < 150; n++) begin
            wr  = 1'($urandom_range(0, 1));
            idx = 64 + $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, 6); sel = sel_tab[k]; off = off_tab[k];
            end else begin
                sel = 4'($urandom); off = 2'($urandom);
            end
            addr = idx * 4 + off;
            oor  = ($urandom_range(0, 7) == 0);
            if (oor) addr[12 + $urandom_range(0, 19)] = 1'b1;
            wd = $urandom;
            legal = 1'b0;
            for (int t = 0; t < 7; t++) if (sel_tab[t] == sel && off_tab[t] == off) legal = 1'b1;
            legal = legal && !oor;
            xact(3, wr, sel, addr, wd, ns, nd, ne, da, ea, rdd, rde);
            if (!legal) begin
                e_ns = 0; e_nd = 0; e_da = -1; e_ne = 1;
            end else if (wr) begin
                e_ns = 0; e_nd = 1; e_da = 1; e_ne = 0;
                w = mdl[idx];
                for (int b = 0; b < 4; b++) if (sel[3-b]) w[31-8*b -: 8] = wd[31-8*b -: 8];
                mdl[idx] = w;
            end else begin
                e_ns = 3; e_nd = 1; e_da = 3; e_ne = 0;
                exp_rd3 = mdl[idx];
            end
            checks++;
            if (ns !== e_ns || nd !== e_nd || da !== e_da || ne !== e_ne) begin
                errors++;
                $display("FAIL rand%0d_ctrl wr=%b sel=%b addr=%h got stall=%0d done=%0d@%0d err=%0d expected %0d %0d@%0d %0d",
                         n, wr, sel, addr, ns, nd, da, ne, e_ns, e_nd, e_da, e_ne);
            end
            checks++;
            if (rde !== exp_rd3 || (legal && !wr && rdd !== exp_rd3)) begin
                errors++;
                $display("FAIL rand%0d_rdata wr=%b addr=%h got %h/%h expected %h", n, wr, addr, rdd, rde, exp_rd3);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic st, dn, er;
        logic [31:0] rd;
        int ns, nd, ne, da, ea;
        logic [31:0] rdd, rde;
        xact(4, 1'b1, 4'hF, 32'h40, 32'h13579BDF, ns, nd, ne, da, ea, rdd, rde);
        @(posedge clk); #1 set_bus(4, 1'b1, 1'b0, 4'hF, 32'h40, '0);
        @(negedge clk); get_out(4, st, dn, er, rd);
        @(posedge clk); @(negedge clk); get_out(4, st, dn, er, rd);
        checks++;
        if (st !== 1'b1) begin errors++; $display("FAIL midrd_wait_stall got %b expected 1", st); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); get_out(4, st, dn, er, rd);
        checks++;
        if (st !== 1'b0) begin errors++; $display("FAIL midrd_stall_forced got %b expected 0", st); end
        @(posedge clk); #1 rst = 1'b1; set_bus(4, 1'b0, 1'b0, '0, '0, '0);
        nd = 0; ns = 0;
        repeat (6) begin
            @(negedge clk); get_out(4, st, dn, er, rd);
            if (dn) nd++;
            if (st) ns++;
        end
        checks++;
        if (nd !== 0 || ns !== 0 || rd !== 32'h0) begin
            errors++; $display("FAIL midrd_aborted got done=%0d stall=%0d rdata=%h expected 0 0 00000000", nd, ns, rd);
        end
        xact(4, 1'b0, 4'hF, 32'h40, '0, ns, nd, ne, da, ea, rdd, rde);
        checks++;
        if (ns !== 4 || nd !== 1 || da !== 4 || rdd !== 32'h13579BDF) begin
            errors++; $display("FAIL midrd_reload got stall=%0d done=%0d@%0d rdata=%h expected 4 1@4 13579bdf", ns, nd, da, rdd);
        end
    endtask

    initial begin
        set_bus(1, 1'b0, 1'b0, '0, '0, '0);
        set_bus(3, 1'b0, 1'b0, '0, '0, '0);
        set_bus(4, 1'b0, 1'b0, '0, '0, '0);
        test_reset();
        test_word();
        test_lanes();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
